// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter between instruction fetch and load/store, one transaction at a time.
// Optional performance counters (stall_cycles, conflicts) are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  conflicts
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IF_REQ  = 3'd1,
        IF_WAIT = 3'd2,
        DM_REQ  = 3'd3,
        DM_WAIT = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic grant_if;
    logic grant_dm;
    logic handshake;
    logic if_cap;
    logic dm_cap;
    logic store_done;

    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        handshake  = 1'b0;
        if_cap     = 1'b0;
        dm_cap     = 1'b0;
        store_done = 1'b0;
        case (state)
            IDLE: begin
                // A request whose valid pulse is showing this cycle is still
                // asserted by the pipeline; granting now would repeat it.
                if (!if_valid && !dm_valid) begin
                    if (dm_req) begin
                        grant_dm   = 1'b1;
                        state_next = DM_REQ;
                    end else if (if_req) begin
                        grant_if   = 1'b1;
                        state_next = IF_REQ;
                    end
                end
            end
            IF_REQ: begin
                if (mem_ready) begin
                    handshake  = 1'b1;
                    state_next = IF_WAIT;
                end
            end
            DM_REQ: begin
                if (mem_ready) begin
                    handshake = 1'b1;
                    if (mem_we) begin
                        store_done = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = DM_WAIT;
                    end
                end
            end
            IF_WAIT: begin
                if (mem_rvalid) begin
                    if_cap     = 1'b1;
                    state_next = IDLE;
                end
            end
            DM_WAIT: begin
                if (mem_rvalid) begin
                    dm_cap     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            state    <= state_next;
            if_valid <= if_cap;
            dm_valid <= dm_cap | store_done;
            if (grant_dm) begin
                mem_req   <= 1'b1;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (grant_if) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
            end else if (handshake) begin
                // Drop the write strobe with the request so memory never sees a bare strobe.
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
            if (if_cap) begin
                if_rdata <= mem_rdata;
            end
            if (dm_cap) begin
                dm_rdata <= mem_rdata;
            end
        end
    end

    assign stall_mem = ~reset & dm_req & ~dm_valid;
    assign stall_if  = ~reset & (stall_mem | (if_req & ~if_valid));

`ifdef ARB_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic conflict_hit;
    assign conflict_hit = (grant_if | grant_dm) & if_req & dm_req;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            conflicts    <= '0;
        end else begin
            if (stall_if && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
            if (conflict_hit && (conflicts != '1)) begin
                conflicts <= conflicts + CNT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter; table-driven cycles plus hand-written reset/saturation sequences.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;
`ifdef ARB_PERF_CNT_EN
    logic [3:0]  stall_cycles;
    logic [3:0]  conflicts;
`endif

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
`ifdef ARB_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .conflicts(conflicts)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!reset && mem_req && mem_ready) hs_cnt <= hs_cnt + 1;
    end

    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_ifv;
        logic        e_dmv;
        logic [31:0] e_rd;
        logic        e_sif;
        logic        e_smem;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(
        input logic i_req, input logic [31:0] i_addr,
        input logic d_req, input logic d_we, input logic [31:0] d_addr, input logic [31:0] d_wdata,
        input logic rdy, input logic rv, input logic [31:0] rd,
        input logic e_req, input logic e_we, input logic [31:0] e_addr, input logic [31:0] e_wdata,
        input logic e_ifv, input logic e_dmv, input logic [31:0] e_rd,
        input logic e_sif, input logic e_smem);
        vec_t r;
        r.i_req = i_req;  r.i_addr = i_addr;
        r.d_req = d_req;  r.d_we = d_we; r.d_addr = d_addr; r.d_wdata = d_wdata;
        r.rdy = rdy;      r.rv = rv;     r.rd = rd;
        r.e_req = e_req;  r.e_we = e_we; r.e_addr = e_addr; r.e_wdata = e_wdata;
        r.e_ifv = e_ifv;  r.e_dmv = e_dmv; r.e_rd = e_rd;
        r.e_sif = e_sif;  r.e_smem = e_smem;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;

        // Fetch only at 0x40, minimum latency
        vecs.push_back(v(1,32'h40,0,0,0,0, 0,0,0,            0,0,0,0, 0,0,0, 1,0));
        vecs.push_back(v(1,32'h40,0,0,0,0, 1,0,0,            1,0,32'h40,0, 0,0,0, 1,0));
        vecs.push_back(v(1,32'h40,0,0,0,0, 0,1,32'h20080005, 0,0,0,0, 0,0,0, 1,0));
        vecs.push_back(v(1,32'h40,0,0,0,0, 0,0,0,            0,0,0,0, 1,0,32'h20080005, 0,0));
        vecs.push_back(v(0,0,0,0,0,0,      0,0,0,            0,0,0,0, 0,0,0, 0,0));
        // Conflict: load 0x10 wins, fetch 0x44 after dm_valid
        vecs.push_back(v(1,32'h44,1,0,32'h10,0, 0,0,0,            0,0,0,0, 0,0,0, 1,1));
        vecs.push_back(v(1,32'h44,1,0,32'h10,0, 1,0,0,            1,0,32'h10,0, 0,0,0, 1,1));
        vecs.push_back(v(1,32'h44,1,0,32'h10,0, 0,1,32'h11112222, 0,0,0,0, 0,0,0, 1,1));
        vecs.push_back(v(1,32'h44,1,0,32'h10,0, 1,0,0,            0,0,0,0, 0,1,32'h11112222, 1,0));
        vecs.push_back(v(1,32'h44,0,0,0,0,      0,0,0,            0,0,0,0, 0,0,0, 1,0));
        vecs.push_back(v(1,32'h44,0,0,0,0,      1,0,0,            1,0,32'h44,0, 0,0,0, 1,0));
        vecs.push_back(v(1,32'h44,0,0,0,0,      0,1,32'h33334444, 0,0,0,0, 0,0,0, 1,0));
        vecs.push_back(v(1,32'h44,0,0,0,0,      0,0,0,            0,0,0,0, 1,0,32'h33334444, 0,0));
        vecs.push_back(v(0,0,0,0,0,0,           0,0,0,            0,0,0,0, 0,0,0, 0,0));
        // Store 0xDEADBEEF to 0x20 with ready low for 3 cycles; stray rvalid ignored
        vecs.push_back(v(0,0,1,1,32'h20,32'hDEADBEEF, 0,0,0,            0,0,0,0, 0,0,0, 1,1));
        vecs.push_back(v(0,0,1,1,32'h20,32'hDEADBEEF, 0,0,0,            1,1,32'h20,32'hDEADBEEF, 0,0,0, 1,1));
        vecs.push_back(v(0,0,1,1,32'h20,32'hDEADBEEF, 0,1,32'h55555555, 1,1,32'h20,32'hDEADBEEF, 0,0,0, 1,1));
        vecs.push_back(v(0,0,1,1,32'h20,32'hDEADBEEF, 0,0,0,            1,1,32'h20,32'hDEADBEEF, 0,0,0, 1,1));
        vecs.push_back(v(0,0,1,1,32'h20,32'hDEADBEEF, 1,0,0,            1,1,32'h20,32'hDEADBEEF, 0,0,0, 1,1));
        vecs.push_back(v(0,0,1,1,32'h20,32'hDEADBEEF, 0,0,0,            0,0,0,0, 0,1,0, 0,0));
        vecs.push_back(v(0,0,0,0,0,0,                 0,0,0,            0,0,0,0, 0,0,0, 0,0));
        // Back-to-back fetches 0x0 then 0x4 with req held; ready offered during the valid cycle
        vecs.push_back(v(1,32'h0,0,0,0,0, 0,0,0,            0,0,0,0, 0,0,0, 1,0));
        vecs.push_back(v(1,32'h0,0,0,0,0, 1,0,0,            1,0,32'h0,0, 0,0,0, 1,0));
        vecs.push_back(v(1,32'h0,0,0,0,0, 0,1,32'hAAAA0001, 0,0,0,0, 0,0,0, 1,0));
        vecs.push_back(v(1,32'h0,0,0,0,0, 1,0,0,            0,0,0,0, 1,0,32'hAAAA0001, 0,0));
        vecs.push_back(v(1,32'h4,0,0,0,0, 0,0,0,            0,0,0,0, 0,0,0, 1,0));
        vecs.push_back(v(1,32'h4,0,0,0,0, 1,0,0,            1,0,32'h4,0, 0,0,0, 1,0));
        vecs.push_back(v(1,32'h4,0,0,0,0, 0,1,32'hAAAA0002, 0,0,0,0, 0,0,0, 1,0));
        vecs.push_back(v(1,32'h4,0,0,0,0, 0,0,0,            0,0,0,0, 1,0,32'hAAAA0002, 0,0));
        vecs.push_back(v(0,0,0,0,0,0,     0,0,0,            0,0,0,0, 0,0,0, 0,0));

        // Reset state
        #2;
        if_req = 1; dm_req = 1;
        #1;
        check("rst mem_req", {31'd0, mem_req}, 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst if_valid", {31'd0, if_valid}, 32'd0);
        check("rst dm_valid", {31'd0, dm_valid}, 32'd0);
        check("rst stall_if", {31'd0, stall_if}, 32'd0);
        check("rst stall_mem", {31'd0, stall_mem}, 32'd0);
        if_req = 0; dm_req = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if_req = vecs[i].i_req;   if_addr = vecs[i].i_addr;
            dm_req = vecs[i].d_req;   dm_we = vecs[i].d_we;
            dm_addr = vecs[i].d_addr; dm_wdata = vecs[i].d_wdata;
            mem_ready = vecs[i].rdy;  mem_rvalid = vecs[i].rv; mem_rdata = vecs[i].rd;
            @(negedge clock);
            check($sformatf("v%0d mem_req", i), {31'd0, mem_req}, {31'd0, vecs[i].e_req});
            check($sformatf("v%0d if_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].e_ifv});
            check($sformatf("v%0d dm_valid", i), {31'd0, dm_valid}, {31'd0, vecs[i].e_dmv});
            check($sformatf("v%0d stall_if", i), {31'd0, stall_if}, {31'd0, vecs[i].e_sif});
            check($sformatf("v%0d stall_mem", i), {31'd0, stall_mem}, {31'd0, vecs[i].e_smem});
            if (vecs[i].e_req) begin
                check($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
                check($sformatf("v%0d mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].e_we});
                if (vecs[i].e_we) check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
            end
            if (vecs[i].e_ifv) check($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].e_rd);
            if (vecs[i].e_dmv && !vecs[i].d_we) check($sformatf("v%0d dm_rdata", i), dm_rdata, vecs[i].e_rd);
            tick();
        end
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        check("handshakes", hs_cnt, 32'd6);
`ifdef ARB_PERF_CNT_EN
        check("conflicts", {28'd0, conflicts}, 32'd1);
`endif

        // Reset during IF_WAIT, then a late rvalid
        if_req = 1; if_addr = 32'h80;
        tick();
        mem_ready = 1;
        tick();
        mem_ready = 0; dm_req = 1;
        #2 reset = 1'b1;
        #1;
        check("midrst mem_req", {31'd0, mem_req}, 32'd0);
        check("midrst mem_addr", mem_addr, 32'd0);
        check("midrst if_valid", {31'd0, if_valid}, 32'd0);
        check("midrst stall_if", {31'd0, stall_if}, 32'd0);
        check("midrst stall_mem", {31'd0, stall_mem}, 32'd0);
        tick();
        if_req = 0; dm_req = 0;
        reset = 1'b0;
`ifdef ARB_PERF_CNT_EN
        check("rst conflicts", {28'd0, conflicts}, 32'd0);
        check("rst stall_cycles", {28'd0, stall_cycles}, 32'd0);
`endif
        mem_rvalid = 1; mem_rdata = 32'hBADBAD00;
        @(negedge clock);
        check("late rv if_valid0", {31'd0, if_valid}, 32'd0);
        tick();
        mem_rvalid = 0; mem_rdata = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check($sformatf("post rst if_valid c%0d", k), {31'd0, if_valid}, 32'd0);
            check($sformatf("post rst mem_req c%0d", k), {31'd0, mem_req}, 32'd0);
            check($sformatf("post rst if_rdata c%0d", k), if_rdata, 32'd0);
            tick();
        end
        if_req = 1; if_addr = 32'h90;
        tick();
        @(negedge clock);
        check("new req mem_req", {31'd0, mem_req}, 32'd1);
        check("new req mem_addr", mem_addr, 32'h90);
        mem_ready = 1;
        tick();
        mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0BADF00D;
        tick();
        mem_rvalid = 0; mem_rdata = 0;
        @(negedge clock);
        check("new req if_valid", {31'd0, if_valid}, 32'd1);
        check("new req if_rdata", if_rdata, 32'h0BADF00D);
        tick();
        if_req = 0;
        tick();

`ifdef ARB_PERF_CNT_EN
        // Saturation of the 4-bit stall counter
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if_req = 1; if_addr = 32'hC0;
        repeat (20) tick();
        check("stall_cycles sat", {28'd0, stall_cycles}, 32'hF);
        if_req = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
